// File: rtl/vga_pixel_out_if.sv
// Pixel-fetch port between the VGA output stage and the frame-buffer read FIFO.
// The master side is the pixel reader; the slave side is the FIFO.
interface vga_pixel_out_if;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/vga_pixel_out.sv
// VGA output stage: 640x480@60 timing generator, two-stage pixel pipeline from the
// read FIFO, and sticky underflow detection with a substitute colour.
module vga_pixel_out #(
    parameter int          H_SYNC   = 96,
    parameter int          H_BACK   = 48,
    parameter int          H_ACTIVE = 640,
    parameter int          H_FRONT  = 16,
    parameter int          V_SYNC   = 2,
    parameter int          V_BACK   = 33,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FRONT  = 10,
    parameter logic [15:0] UF_COLOR = 16'hF800
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    vga_pixel_out_if.master    fifo,
    input  logic               clr_underflow,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic [15:0]        rgb,
    output logic               frame_start,
    output logic               underflow
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_DE_BEG   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_DE_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_DE_BEG   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_DE_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

    logic [9:0]  h_cnt_r;
    logic [9:0]  v_cnt_r;

    logic        hs0_s;
    logic        vs0_s;
    logic        de0_s;
    logic        miss0_s;
    logic        rd_en_s;

    logic        hs1_r;
    logic        vs1_r;
    logic        de1_r;
    logic        miss1_r;
    logic        vs1_d_r;

    logic [15:0] rgb_s;

    // Pixel/line counters; held at the frame origin while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (!en) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
        end
    end

    // Stage-0 timing decode; everything is forced inactive while disabled so a
    // dropped enable cannot stretch a sync pulse or issue a read.
    always_comb begin
        hs0_s   = 1'b0;
        vs0_s   = 1'b0;
        de0_s   = 1'b0;
        if (en) begin
            hs0_s = (h_cnt_r < H_SYNC_END);
            vs0_s = (v_cnt_r < V_SYNC_END);
            de0_s = (h_cnt_r >= H_DE_BEG) && (h_cnt_r < H_DE_END) &&
                    (v_cnt_r >= V_DE_BEG) && (v_cnt_r < V_DE_END);
        end else begin
            hs0_s = 1'b0;
            vs0_s = 1'b0;
            de0_s = 1'b0;
        end
        miss0_s = de0_s & fifo.fifo_empty;
        rd_en_s = de0_s & ~fifo.fifo_empty;
    end

    assign fifo.fifo_rd_en = rd_en_s;

    // Stage 1: timing flags aligned with the cycle in which the FIFO returns data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs1_r   <= 1'b0;
            vs1_r   <= 1'b0;
            de1_r   <= 1'b0;
            miss1_r <= 1'b0;
            vs1_d_r <= 1'b0;
        end else begin
            hs1_r   <= hs0_s;
            vs1_r   <= vs0_s;
            de1_r   <= de0_s;
            miss1_r <= miss0_s;
            vs1_d_r <= vs1_r;
        end
    end

    // Pixel select: a missed slot shows the underflow colour, blanking shows black.
    always_comb begin
        rgb_s = 16'h0000;
        if (de1_r) begin
            if (miss1_r) begin
                rgb_s = UF_COLOR;
            end else begin
                rgb_s = fifo.fifo_rd_data;
            end
        end else begin
            rgb_s = 16'h0000;
        end
    end

    // Stage 2: registered pins; frame_start coincides with the falling edge of vga_vs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_de      <= 1'b0;
            rgb         <= 16'h0000;
            frame_start <= 1'b0;
        end else begin
            vga_hs      <= ~hs1_r;
            vga_vs      <= ~vs1_r;
            vga_de      <= de1_r;
            rgb         <= rgb_s;
            frame_start <= vs1_r & ~vs1_d_r;
        end
    end

    // Sticky underflow flag; a new miss wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (miss0_s) begin
            underflow <= 1'b1;
        end else if (clr_underflow) begin
            underflow <= 1'b0;
        end else begin
            underflow <= underflow;
        end
    end

endmodule
